// File: rtl/aes_result_streamer.sv
// Captures a 128-bit cipher result on the rising edge of done and streams it MSB byte first
// over a valid/ready byte port. Define AES_STREAM_CSUM_EN to append an XOR checksum byte.
module aes_result_streamer (
    input  logic         clk,
    input  logic         rst,
    input  logic         done,
    input  logic [127:0] text_in,
    input  logic         clr_ovr,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    output logic         out_last,
    output logic         busy,
    output logic         overrun
);
    // state    | meaning
    // S_IDLE   | no block held, waiting for a done rise
    // S_STREAM | presenting shreg[127:120], advancing on each accepted byte
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

`ifdef AES_STREAM_CSUM_EN
    localparam logic [4:0] LAST_IDX = 5'd16;
    logic [7:0] csum;
`else
    localparam logic [4:0] LAST_IDX = 5'd15;
`endif

    logic [0:0]   state;
    logic         done_q;
    logic [4:0]   cnt;
    logic [127:0] shreg;
    logic         ovr_q;
    logic         rise;
    logic         streaming;
    logic         xfer;
    logic         last_xfer;
    logic         load;
    logic         ovr_evt;

    assign rise      = done & ~done_q;
    assign streaming = (state == S_STREAM);
    assign xfer      = streaming & out_ready;
    assign last_xfer = xfer & (cnt == LAST_IDX);
    // A rise coinciding with the final transfer chains straight into the next block.
    assign load      = rise & (~streaming | last_xfer);
    assign ovr_evt   = rise & streaming & ~last_xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
            cnt    <= 5'd0;
            shreg  <= 128'd0;
            ovr_q  <= 1'b0;
`ifdef AES_STREAM_CSUM_EN
            csum   <= 8'd0;
`endif
        end else begin
            done_q <= done;
            if (ovr_evt)
                ovr_q <= 1'b1;
            else if (clr_ovr)
                ovr_q <= 1'b0;

            if (load) begin
                shreg <= text_in;
                cnt   <= 5'd0;
                state <= S_STREAM;
`ifdef AES_STREAM_CSUM_EN
                csum  <= 8'd0;
`endif
            end else if (last_xfer) begin
                shreg <= 128'd0;
                cnt   <= 5'd0;
                state <= S_IDLE;
            end else if (xfer) begin
                cnt <= cnt + 5'd1;
`ifdef AES_STREAM_CSUM_EN
                csum <= csum ^ shreg[127:120];
                // After the 16th data byte the checksum takes the head of the register.
                if (cnt == 5'd15)
                    shreg <= {csum ^ shreg[127:120], 120'd0};
                else
                    shreg <= {shreg[119:0], 8'h00};
`else
                shreg <= {shreg[119:0], 8'h00};
`endif
            end
        end
    end

    assign out_data  = shreg[127:120];
    assign out_valid = streaming;
    assign out_last  = streaming & (cnt == LAST_IDX);
    assign busy      = streaming;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_aes_result_streamer.sv
// Self-checking bench for aes_result_streamer: table-driven blocks plus overrun,
// back-to-back, reset and held-done sequences, all checked through a byte scoreboard.
module tb_aes_result_streamer;
    logic         clk = 1'b0;
    logic         rst;
    logic         done;
    logic [127:0] text_in;
    logic         clr_ovr;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_last;
    logic         busy;
    logic         overrun;

`ifdef AES_STREAM_CSUM_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [127:0] text;
        int           mode;   // 0: ready high, 1: toggling, 2: random
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ready_mode = 0;
    vec_t vecs[5];

    aes_result_streamer dut (
        .clk(clk), .rst(rst), .done(done), .text_in(text_in), .clr_ovr(clr_ovr),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_block(input logic [127:0] t);
        logic [7:0] cs;
        exp_t e;
        cs = 8'd0;
        for (int i = 0; i < 16; i++) begin
            e.data = t[127 - 8*i -: 8];
            e.last = (i == 15) && (NB == 16);
            cs = cs ^ e.data;
            exp_q.push_back(e);
        end
        if (NB == 17) begin
            e.data = cs;
            e.last = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Check the current cycle, advance one clock, then update out_ready.
    task automatic cycle();
        exp_t e;
        if (exp_q.size() > 0) chk("valid_gap", out_valid, 1);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_byte", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data", out_data, e.data);
                chk("last", out_last, e.last);
            end
        end
        @(posedge clk);
        #1;
        case (ready_mode)
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    endtask

    task automatic pulse(input logic [127:0] t);
        text_in = t;
        done = 1'b1;
        cycle();
        push_block(t);
        done = 1'b0;
    endtask

    task automatic drain(output int k);
        k = 0;
        while (exp_q.size() > 0 && k < 300) begin
            cycle();
            k++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        chk("busy_after", busy, 0);
        chk("valid_after", out_valid, 0);
    endtask

    task automatic run_until_left(input int left);
        int k;
        k = 0;
        while (exp_q.size() > left && k < 300) begin
            cycle();
            k++;
        end
        if (exp_q.size() > left) chk("advance_timeout", exp_q.size(), left);
    endtask

    initial begin
        int k;
        vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 0};
        vecs[1] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 1};
        vecs[2] = '{128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 2};
        vecs[3] = '{128'h0, 0};
        vecs[4] = '{{128{1'b1}}, 1};

        rst = 1'b1; done = 1'b0; clr_ovr = 1'b0; out_ready = 1'b1; text_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        cycle();

        for (int v = 0; v < 5; v++) begin
            ready_mode = vecs[v].mode;
            out_ready = 1'b1;
            pulse(vecs[v].text);
            drain(k);
            if (vecs[v].mode == 0) chk("stream_len", k, NB);
            chk("no_ovr", overrun, 0);
            cycle();
        end
        ready_mode = 0;
        out_ready = 1'b1;

        // New result while byte 5 is pending: dropped, flagged, first block continues.
        pulse(128'h01020304_05060708_090A0B0C_0D0E0F10);
        run_until_left(NB - 5);
        out_ready = 1'b0;
        ready_mode = 1;
        text_in = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        done = 1'b1;
        cycle();
        done = 1'b0;
        chk("ovr_set", overrun, 1);
        drain(k);
        ready_mode = 0;
        chk("ovr_sticky", overrun, 1);
        clr_ovr = 1'b1;
        cycle();
        clr_ovr = 1'b0;
        chk("ovr_clr", overrun, 0);

        // Clear coinciding with a fresh overrun: set wins.
        pulse(128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A);
        run_until_left(NB - 3);
        done = 1'b1;
        clr_ovr = 1'b1;
        cycle();
        done = 1'b0;
        clr_ovr = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        drain(k);
        clr_ovr = 1'b1;
        cycle();
        clr_ovr = 1'b0;
        chk("ovr_clr2", overrun, 0);

        // Rise on the same edge as the last-byte transfer: seamless next block.
        pulse(128'h11111111_22222222_33333333_44444444);
        run_until_left(1);
        chk("pre_last", out_last, 1);
        pulse(128'h55555555_66666666_77777777_88888888);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", out_data, 8'h55);
        chk("b2b_no_ovr", overrun, 0);
        drain(k);
        chk("b2b_len", k, NB);

        // Reset mid-stream with done held high through release.
        pulse(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        run_until_left(NB - 8);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_busy", busy, 0);
        exp_q.delete();
        done = 1'b1;
        text_in = 128'h13579BDF_02468ACE_FDB97531_ECA86420;
        @(posedge clk);
        #1;
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_last", out_last, 0);
        rst = 1'b0;
        cycle();
        push_block(text_in);
        drain(k);
        chk("post_rst_len", k, NB);
        chk("post_rst_ovr", overrun, 0);
        done = 1'b0;
        cycle();

        // done held for 10 cycles: one block only.
        text_in = 128'hC0FFEE00_11223344_55667788_99AABBCC;
        done = 1'b1;
        cycle();
        push_block(text_in);
        for (int i = 0; i < 9; i++) cycle();
        done = 1'b0;
        drain(k);
        chk("held_ovr", overrun, 0);
        repeat (3) cycle();
        chk("held_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
